// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM state codes,
// writeback-select values and register index width.
package hazard_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MDU_WAIT = 2'd1;
    localparam logic [1:0] ST_PAUSED   = 2'd2;
    localparam logic [1:0] ST_STEP     = 2'd3;

    localparam logic [1:0] WD_SEL_LOAD = 2'b01;

    // A read port hits a pending load destination (x0 never hazards).
    function automatic logic src_hit(
        input logic                 re,
        input logic [REG_IDX_W-1:0] ra,
        input logic [REG_IDX_W-1:0] wa
    );
        return re && (ra == wa) && (wa != '0);
    endfunction

endpackage

// File: rtl/hazard_mdu_watchdog.sv
// MDU watchdog: counts MDU_WAIT cycles, flags a timeout on the last allowed
// cycle and keeps a sticky error until reset.
module hazard_mdu_watchdog #(
    parameter int MDU_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic in_wait,
    input  logic done,
    output logic timeout,
    output logic mdu_err
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(MDU_TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    assign timeout = in_wait && !done && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (in_wait && !done && !timeout) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdu_err <= 1'b0;
        end else if (timeout) begin
            mdu_err <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, EX jump
// flushes, multi-cycle MDU waits and debug pause/step.
// Optional perf counters are enabled with `define HAZARD_PERF_CNT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal flow; jump flush / load-use bubble applied
// MDU_WAIT  | whole pipe held, MEM/WB bubbled until mdu_done or timeout
// PAUSED    | debug pause, all four stalls held
// STEP      | one RUN-rules cycle, then back to PAUSED
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [REG_IDX_W-1:0] rf_ra0_id,
    input  logic [REG_IDX_W-1:0] rf_ra1_id,
    input  logic                 rf_re0_id,
    input  logic                 rf_re1_id,
    input  logic [REG_IDX_W-1:0] rf_wa_ex,
    input  logic                 rf_we_ex,
    input  logic [1:0]           rf_wd_sel_ex,
    input  logic                 jump_ex,
    input  logic                 mdu_start_ex,
    input  logic                 mdu_done,
    input  logic                 dbg_run,
    input  logic                 dbg_step,
    output logic                 stall_pc,
    output logic                 stall_if_id,
    output logic                 stall_id_ex,
    output logic                 stall_ex_mem,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_mem_wb,
    output logic                 mdu_err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]          lu_stall_cnt,
    output logic [31:0]          flush_cnt,
    output logic [31:0]          mdu_stall_cnt,
`endif
    output logic [1:0]           ctrl_state
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       lu;
    logic       run_rules;
    logic       mdu_go;
    logic       wd_clr;
    logic       wd_timeout;

    assign lu = rf_we_ex && (rf_wd_sel_ex == WD_SEL_LOAD) &&
                (src_hit(rf_re0_id, rf_ra0_id, rf_wa_ex) ||
                 src_hit(rf_re1_id, rf_ra1_id, rf_wa_ex));

    assign run_rules = (state == ST_RUN) || (state == ST_STEP);

    // A jump in the same cycle squashes the MDU start; a same-cycle done needs no wait.
    assign mdu_go = mdu_start_ex && !mdu_done && !jump_ex;

    assign ctrl_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wd_clr    = 1'b0;
        case (state)
            ST_RUN, ST_STEP: begin
                if (mdu_go) begin
                    state_nxt = ST_MDU_WAIT;
                    wd_clr    = 1'b1;
                end else if (state == ST_STEP || !dbg_run) begin
                    state_nxt = ST_PAUSED;
                end
            end
            ST_MDU_WAIT: begin
                if (mdu_done) begin
                    state_nxt = dbg_run ? ST_RUN : ST_PAUSED;
                end else if (wd_timeout) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (dbg_run) begin
                    state_nxt = ST_RUN;
                end else if (dbg_step) begin
                    state_nxt = ST_STEP;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Outputs are forced quiet while reset is held, whatever the ID/EX inputs show.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        if (rstn) begin
            case (state)
                ST_RUN, ST_STEP: begin
                    if (jump_ex) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (lu) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
                ST_MDU_WAIT: begin
                    if (!mdu_done) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        stall_ex_mem = 1'b1;
                        flush_mem_wb = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    stall_ex_mem = 1'b1;
                end
                default: ;
            endcase
        end
    end

    hazard_mdu_watchdog #(
        .MDU_TIMEOUT (MDU_TIMEOUT),
        .TO_W        (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (wd_clr),
        .in_wait (state == ST_MDU_WAIT),
        .done    (mdu_done),
        .timeout (wd_timeout),
        .mdu_err (mdu_err)
    );

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lu_stall_cnt  <= '0;
            flush_cnt     <= '0;
            mdu_stall_cnt <= '0;
        end else begin
            if (run_rules && !jump_ex && lu) begin
                lu_stall_cnt <= lu_stall_cnt + 32'd1;
            end
            if (run_rules && jump_ex) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (state == ST_MDU_WAIT) begin
                mdu_stall_cnt <= mdu_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each cycle's expected outputs are
// queued when inputs are driven and compared on the following falling edge.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_LU    = 7'b1100010;
    localparam logic [6:0] O_JMP   = 7'b0000110;
    localparam logic [6:0] O_MDU   = 7'b1111001;
    localparam logic [6:0] O_PAUSE = 7'b1111000;
    localparam logic [1:0] S_RUN = 2'd0, S_MDU = 2'd1, S_PAU = 2'd2, S_STP = 2'd3;

    typedef struct packed {
        logic [6:0] o;
        logic [1:0] s;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] rf_ra0_id, rf_ra1_id, rf_wa_ex;
    logic       rf_re0_id, rf_re1_id, rf_we_ex;
    logic [1:0] rf_wd_sel_ex;
    logic       jump_ex, mdu_start_ex, mdu_done, dbg_run, dbg_step;
    logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic       flush_if_id, flush_id_ex, flush_mem_wb, mdu_err;
    logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_stall_cnt, flush_cnt, mdu_stall_cnt;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_cyc  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MDU_TIMEOUT (8),
        .TO_W        (7)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rf_ra0_id    (rf_ra0_id),
        .rf_ra1_id    (rf_ra1_id),
        .rf_re0_id    (rf_re0_id),
        .rf_re1_id    (rf_re1_id),
        .rf_wa_ex     (rf_wa_ex),
        .rf_we_ex     (rf_we_ex),
        .rf_wd_sel_ex (rf_wd_sel_ex),
        .jump_ex      (jump_ex),
        .mdu_start_ex (mdu_start_ex),
        .mdu_done     (mdu_done),
        .dbg_run      (dbg_run),
        .dbg_step     (dbg_step),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_mem_wb (flush_mem_wb),
        .mdu_err      (mdu_err),
`ifdef HAZARD_PERF_CNT_EN
        .lu_stall_cnt (lu_stall_cnt),
        .flush_cnt    (flush_cnt),
        .mdu_stall_cnt(mdu_stall_cnt),
`endif
        .ctrl_state   (ctrl_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : sb_check
        exp_t x;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check_eq($sformatf("out@%0d", n_cyc),
                     {25'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                      flush_if_id, flush_id_ex, flush_mem_wb}, {25'd0, x.o});
            check_eq($sformatf("state@%0d", n_cyc), {30'd0, ctrl_state}, {30'd0, x.s});
            check_eq($sformatf("err@%0d", n_cyc), {31'd0, mdu_err}, {31'd0, x.e});
            n_cyc++;
        end
    end

    task automatic cyc(input logic [6:0] eo, input logic [1:0] es, input logic ee);
        exp_t x;
        x.o = eo;
        x.s = es;
        x.e = ee;
        sb.push_back(x);
        @(posedge clk);
        #1;
        mdu_start_ex = 1'b0;
        mdu_done     = 1'b0;
        dbg_step     = 1'b0;
        jump_ex      = 1'b0;
    endtask

    task automatic set_lu(input logic we, input logic [1:0] sel, input logic [4:0] wa,
                          input logic re0, input logic [4:0] ra0,
                          input logic re1, input logic [4:0] ra1);
        rf_we_ex     = we;
        rf_wd_sel_ex = sel;
        rf_wa_ex     = wa;
        rf_re0_id    = re0;
        rf_ra0_id    = ra0;
        rf_re1_id    = re1;
        rf_ra1_id    = ra1;
    endtask

    initial begin
        rstn = 1'b0;
        jump_ex = 1'b0; mdu_start_ex = 1'b0; mdu_done = 1'b0;
        dbg_run = 1'b1; dbg_step = 1'b0;
        set_lu(1'b1, 2'b01, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        @(posedge clk);
        #1;
        // Held in reset with a live load-use pattern: everything quiet.
        cyc(O_NONE, S_RUN, 1'b0);
        jump_ex = 1'b1;
        cyc(O_NONE, S_RUN, 1'b0);
        rstn = 1'b1;

        // Load-use through rs2, then rs1, then the non-hazard variants.
        cyc(O_LU, S_RUN, 1'b0);
        set_lu(1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        cyc(O_NONE, S_RUN, 1'b0);
        set_lu(1'b1, 2'b01, 5'd7, 1'b1, 5'd7, 1'b0, 5'd3);
        cyc(O_LU, S_RUN, 1'b0);
        set_lu(1'b1, 2'b01, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        cyc(O_NONE, S_RUN, 1'b0);
        set_lu(1'b1, 2'b00, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        cyc(O_NONE, S_RUN, 1'b0);
        set_lu(1'b1, 2'b01, 5'd5, 1'b0, 5'd5, 1'b0, 5'd5);
        cyc(O_NONE, S_RUN, 1'b0);
        set_lu(1'b0, 2'b01, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5);
        cyc(O_NONE, S_RUN, 1'b0);

        // Jump overrides load-use; jump squashes a concurrent MDU start.
        set_lu(1'b1, 2'b01, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        jump_ex = 1'b1;
        cyc(O_JMP, S_RUN, 1'b0);
        set_lu(1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        jump_ex = 1'b1; mdu_start_ex = 1'b1;
        cyc(O_JMP, S_RUN, 1'b0);
        cyc(O_NONE, S_RUN, 1'b0);

        // MDU op with done five cycles after the start; a jump mid-wait is ignored.
        mdu_start_ex = 1'b1;
        cyc(O_NONE, S_RUN, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) jump_ex = 1'b1;
            cyc(O_MDU, S_MDU, 1'b0);
        end
        mdu_done = 1'b1;
        cyc(O_NONE, S_MDU, 1'b0);
        cyc(O_NONE, S_RUN, 1'b0);

        // Start and done together: no wait.
        mdu_start_ex = 1'b1; mdu_done = 1'b1;
        cyc(O_NONE, S_RUN, 1'b0);
        cyc(O_NONE, S_RUN, 1'b0);

        // Watchdog: no done, abort after eight wait cycles, error is sticky.
        mdu_start_ex = 1'b1;
        cyc(O_NONE, S_RUN, 1'b0);
        for (int i = 0; i < 8; i++) cyc(O_MDU, S_MDU, 1'b0);
        cyc(O_NONE, S_RUN, 1'b1);
        mdu_done = 1'b1;
        cyc(O_NONE, S_RUN, 1'b1);
        // A fresh wait after the abort restarts the count from zero.
        mdu_start_ex = 1'b1;
        cyc(O_NONE, S_RUN, 1'b1);
        for (int i = 0; i < 7; i++) cyc(O_MDU, S_MDU, 1'b1);
        mdu_done = 1'b1;
        cyc(O_NONE, S_MDU, 1'b1);
        cyc(O_NONE, S_RUN, 1'b1);
        rstn = 1'b0;
        cyc(O_NONE, S_RUN, 1'b0);
        rstn = 1'b1;
        cyc(O_NONE, S_RUN, 1'b0);

        // Debug pause, plain step, step with load-use, step with jump.
        dbg_run = 1'b0;
        cyc(O_NONE, S_RUN, 1'b0);
        cyc(O_PAUSE, S_PAU, 1'b0);
        dbg_step = 1'b1;
        cyc(O_PAUSE, S_PAU, 1'b0);
        cyc(O_NONE, S_STP, 1'b0);
        dbg_step = 1'b1;
        cyc(O_PAUSE, S_PAU, 1'b0);
        set_lu(1'b1, 2'b01, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
        cyc(O_LU, S_STP, 1'b0);
        cyc(O_PAUSE, S_PAU, 1'b0);
        set_lu(1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        dbg_step = 1'b1;
        cyc(O_PAUSE, S_PAU, 1'b0);
        jump_ex = 1'b1;
        cyc(O_JMP, S_STP, 1'b0);
        // Step into an MDU op: wait, then back to PAUSED.
        dbg_step = 1'b1;
        cyc(O_PAUSE, S_PAU, 1'b0);
        mdu_start_ex = 1'b1;
        cyc(O_NONE, S_STP, 1'b0);
        cyc(O_MDU, S_MDU, 1'b0);
        mdu_done = 1'b1;
        cyc(O_NONE, S_MDU, 1'b0);
        // dbg_run wins over a simultaneous step.
        dbg_run = 1'b1; dbg_step = 1'b1;
        cyc(O_PAUSE, S_PAU, 1'b0);
        cyc(O_NONE, S_RUN, 1'b0);

        // Pause requested during MDU wait takes effect only after done.
        mdu_start_ex = 1'b1;
        cyc(O_NONE, S_RUN, 1'b0);
        dbg_run = 1'b0;
        for (int i = 0; i < 3; i++) cyc(O_MDU, S_MDU, 1'b0);
        mdu_done = 1'b1;
        cyc(O_NONE, S_MDU, 1'b0);
        cyc(O_PAUSE, S_PAU, 1'b0);
        dbg_run = 1'b1;
        cyc(O_PAUSE, S_PAU, 1'b0);
        cyc(O_NONE, S_RUN, 1'b0);

        // Reset asserted mid-wait returns to RUN at once.
        mdu_start_ex = 1'b1;
        cyc(O_NONE, S_RUN, 1'b0);
        cyc(O_MDU, S_MDU, 1'b0);
        cyc(O_MDU, S_MDU, 1'b0);
        rstn = 1'b0;
        cyc(O_NONE, S_RUN, 1'b0);
        rstn = 1'b1;
        cyc(O_NONE, S_RUN, 1'b0);

        @(negedge clk);
        #1;
        check_eq("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Sequences the pipeline registers for four cases: load-use hazards the forwarding path cannot cover, taken jumps/branches resolved in EX, multi-cycle MDU operations, and debug pause/single-step.
- Drives stall/flush of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- MDU_TIMEOUT, 64: max cycles waited for mdu_done before watchdog abort.
- TO_W, 7: width of the watchdog counter; must hold MDU_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- rf_ra0_id  in  5  rs1 index of the instruction in ID.
- rf_ra1_id  in  5  rs2 index of the instruction in ID.
- rf_re0_id  in  1  ID instruction reads rs1.
- rf_re1_id  in  1  ID instruction reads rs2.
- rf_wa_ex  in  5  rd index of the instruction in EX.
- rf_we_ex  in  1  EX instruction writes rd.
- rf_wd_sel_ex  in  2  EX writeback select; 2'b01 = load.
- jump_ex  in  1  taken branch/jump resolved in EX.
- mdu_start_ex  in  1  1-cycle pulse: MDU op enters EX.
- mdu_done  in  1  1-cycle pulse: MDU result valid.
- dbg_run  in  1  level; 0 requests pause.
- dbg_step  in  1  1-cycle pulse; single step while paused.
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold the register.
- flush_if_id, flush_id_ex, flush_mem_wb  out  1 each  load a bubble.
- mdu_err  out  1  sticky watchdog-abort flag.
- ctrl_state  out  2  current FSM state, for the debug unit.

Behaviour:
- Reset: all stall/flush outputs 0 while rstn=0; state RUN; watchdog 0; mdu_err 0.
- FSM encoding: RUN=0, MDU_WAIT=1, PAUSED=2, STEP=3. State changes are registered; all stall/flush outputs are combinational from state and inputs.
- Load-use condition lu: rf_we_ex & rf_wd_sel_ex==2'b01 & rf_wa_ex!=0 & ((rf_re0_id & rf_ra0_id==rf_wa_ex) | (rf_re1_id & rf_ra1_id==rf_wa_ex)).
- RUN:
  - jump_ex → flush_if_id=1, flush_id_ex=1. Overrides lu; the ID instruction is wrong-path.
  - else lu → stall_pc=1, stall_if_id=1, flush_id_ex=1. Exactly one bubble.
  - mdu_start_ex & ~mdu_done → next state MDU_WAIT, watchdog cleared.
  - mdu_start_ex & mdu_done in the same cycle → stay in RUN, no stall.
  - else ~dbg_run → next state PAUSED.
- MDU_WAIT:
  - Asserts stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_mem_wb. The MEM instruction retires once; bubbles follow it.
  - Watchdog increments each cycle.
  - mdu_done → RUN (or PAUSED if ~dbg_run); stalls drop in that same cycle.
  - watchdog==MDU_TIMEOUT-1 without done → mdu_err=1, state RUN.
  - Pause requests and jump_ex are ignored until MDU_WAIT exits.
- PAUSED:
  - All four stalls asserted; no flush.
  - dbg_step → STEP.
  - dbg_run=1 → RUN. dbg_run has priority over dbg_step.
- STEP:
  - Exactly one cycle with RUN output rules, so the pipeline advances once; jump/lu are honoured.
  - Next state PAUSED.
  - If mdu_start_ex & ~mdu_done in STEP → MDU_WAIT, then PAUSED after done.
- Jump/MDU interaction: jump_ex and mdu_start_ex are never both 1. If both appear, jump wins and mdu_start_ex is ignored.
- Reset mid-MDU_WAIT: immediate return to RUN; the MDU is reset by the same rstn.
- mdu_err clears only on reset.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs lu_stall_cnt, flush_cnt, mdu_stall_cnt; all reset to 0 and wrap modulo 2^32.
  - lu_stall_cnt +1 per cycle lu stalls.
  - flush_cnt +1 per jump flush.
  - mdu_stall_cnt +1 per MDU_WAIT cycle.
  - No counting in PAUSED.
- Undefined: ports and logic absent; the rest of the block is unchanged.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding localparams ST_RUN/ST_MDU_WAIT/ST_PAUSED/ST_STEP;
  - WD_SEL_LOAD=2'b01;
  - REG_IDX_W=5.
- One natural sub-module: hazard_mdu_watchdog, covering the counter, timeout compare and sticky mdu_err.

Test Plan:
- Load x5 in EX, ID reads x5 via rs2 with re1=1 → one cycle of stall_pc=stall_if_id=flush_id_ex=1; with rf_wa_ex=0 → no stall.
- jump_ex=1 with lu also true → flush_if_id=flush_id_ex=1, stall_pc=0.
- mdu_start_ex pulse, mdu_done 5 cycles later → state 1 for 5 cycles with stalls + flush_mem_wb; RUN and stalls cleared in the done cycle; mdu_err=0.
- MDU_TIMEOUT=8, mdu_start_ex, no done → mdu_err=1 after 8 cycles; state RUN; stays 1 until rstn pulse.
- dbg_run=0 → PAUSED with all stalls; dbg_step pulse → exactly one cycle all outputs 0, back to PAUSED; dbg_run=1 → RUN.
- dbg_run=0 asserted during MDU_WAIT → remain MDU_WAIT until mdu_done, then PAUSED; rstn low mid-wait → RUN and outputs 0 immediately.
